// File: rtl/ps2_direction_decoder.sv
// PS/2 scan-code to lightbike heading decoder for two players.
// Tracks the E0/F0 prefix sequence, matches make codes against each
// player's live keyset and keeps a registered heading per player that
// never reverses by 180 degrees. A one-cycle turn strobe accompanies
// every accepted heading change.
module ps2_direction_decoder #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    input  logic       enable,
    input  logic       load,
    input  logic [2:0] keyset_p1,
    input  logic [2:0] keyset_p2,
    output logic [1:0] dir_p1,
    output logic [1:0] dir_p2,
    output logic       turn_p1,
    output logic       turn_p2
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0]       CODE_EXT = 8'hE0;
    localparam logic [7:0]       CODE_BRK = 8'hF0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Returns {match, heading} for a code under a keyset; unknown keysets use set 2.
    function automatic logic [2:0] key_lookup(input logic [2:0] ks, input logic [7:0] code);
        logic [7:0] kl, kr, ku, kd;
        logic [2:0] r;
        case (ks)
            3'd1:    begin kl = 8'h1C; kr = 8'h23; ku = 8'h1D; kd = 8'h1B; end
            3'd3:    begin kl = 8'h3B; kr = 8'h4B; ku = 8'h43; kd = 8'h42; end
            3'd4:    begin kl = 8'h6B; kr = 8'h74; ku = 8'h75; kd = 8'h73; end
            default: begin kl = 8'h2B; kr = 8'h33; ku = 8'h2C; kd = 8'h34; end
        endcase
        r = 3'b000;
        if (code == ku)      r = {1'b1, 2'd0};
        else if (code == kr) r = {1'b1, 2'd1};
        else if (code == kd) r = {1'b1, 2'd2};
        else if (code == kl) r = {1'b1, 2'd3};
        return r;
    endfunction

    // A turn is legal when it changes the heading and is not a U-turn.
    function automatic logic legal_turn(input logic [1:0] cur, input logic [1:0] nw);
        return (nw != cur) && (nw != (cur ^ 2'd2));
    endfunction

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             make_code;
    logic [2:0]       hit_p1, hit_p2;
    logic             take_p1, take_p2;

    // Prefix FSM next state and prefix timeout counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (scan_valid) begin
            cnt_nxt = '0;
            case (state)
                IDLE: begin
                    if (scan_code == CODE_EXT)      state_nxt = EXT;
                    else if (scan_code == CODE_BRK) state_nxt = BRK;
                    else                            state_nxt = IDLE;
                end
                EXT: begin
                    if (scan_code == CODE_BRK)      state_nxt = EXT_BRK;
                    else if (scan_code == CODE_EXT) state_nxt = EXT;
                    else                            state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE) begin
            if (cnt + CNT_W'(1) == CNT_LAST) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end else begin
            cnt_nxt = '0;
        end
    end

    // Make-code evaluation against each player's live keyset.
    always_comb begin
        make_code = scan_valid && !load && ((state == IDLE) || (state == EXT))
                    && (scan_code != CODE_EXT) && (scan_code != CODE_BRK);
        hit_p1    = key_lookup(keyset_p1, scan_code);
        hit_p2    = key_lookup(keyset_p2, scan_code);
        take_p1   = make_code && enable && hit_p1[2] && legal_turn(dir_p1, hit_p1[1:0]);
        take_p2   = make_code && enable && hit_p2[2] && legal_turn(dir_p2, hit_p2[1:0]);
    end

    // State, counter, headings and turn strobes; load restarts the round.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            dir_p1  <= 2'd1;
            dir_p2  <= 2'd3;
            turn_p1 <= 1'b0;
            turn_p2 <= 1'b0;
        end else if (load) begin
            state   <= IDLE;
            cnt     <= '0;
            dir_p1  <= 2'd1;
            dir_p2  <= 2'd3;
            turn_p1 <= 1'b0;
            turn_p2 <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            turn_p1 <= take_p1;
            turn_p2 <= take_p2;
            if (take_p1) dir_p1 <= hit_p1[1:0];
            if (take_p2) dir_p2 <= hit_p2[1:0];
        end
    end

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Scoreboard bench for ps2_direction_decoder: directed scenarios followed
// by randomized byte streams, checked against a prefix-list reference model.
module tb_ps2_direction_decoder;

    localparam int T = 40;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       scan_valid = 1'b0;
    logic       enable = 1'b0;
    logic       load = 1'b0;
    logic [2:0] keyset_p1 = 3'd1;
    logic [2:0] keyset_p2 = 3'd1;
    logic [1:0] dir_p1, dir_p2;
    logic       turn_p1, turn_p2;

    ps2_direction_decoder #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
        .enable(enable), .load(load), .keyset_p1(keyset_p1), .keyset_p2(keyset_p2),
        .dir_p1(dir_p1), .dir_p2(dir_p2), .turn_p1(turn_p1), .turn_p2(turn_p2)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [5:0] ex;
    } exp_t;
    exp_t sbq[$];

    int n_chk = 0;
    int n_pass = 0;

    // reference model state
    logic [7:0] km [1:4][0:3];
    int         slot_dir [0:3];
    int         m_dir1, m_dir2, idle;
    logic [7:0] pfx[$];

    // values applied with the next step
    logic       en_n = 1'b1;
    logic [2:0] ks1_n = 3'd1;
    logic [2:0] ks2_n = 3'd1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int decode(input logic [2:0] ks, input logic [7:0] c);
        int k;
        k = (ks >= 3'd1 && ks <= 3'd4) ? int'(ks) : 2;
        for (int i = 0; i < 4; i++)
            if (km[k][i] == c) return slot_dir[i];
        return -1;
    endfunction

    function automatic void model_reset();
        m_dir1 = 1;
        m_dir2 = 3;
        pfx.delete();
        idle = 0;
    endfunction

    // Advance the model by one clock; returns expected {dir1,dir2,turn1,turn2}.
    function automatic logic [5:0] model_step(input logic v, input logic [7:0] c, input logic ld);
        logic t1, t2, has_brk;
        int d;
        t1 = 1'b0;
        t2 = 1'b0;
        if (ld) begin
            model_reset();
        end else if (v) begin
            idle = 0;
            has_brk = 1'b0;
            foreach (pfx[i]) if (pfx[i] == 8'hF0) has_brk = 1'b1;
            if (has_brk) begin
                pfx.delete();
            end else if (c == 8'hE0) begin
                pfx.delete();
                pfx.push_back(8'hE0);
            end else if (c == 8'hF0) begin
                pfx.push_back(8'hF0);
            end else begin
                pfx.delete();
                d = decode(keyset_p1, c);
                if (d >= 0 && enable && d != m_dir1 && (d + 2) % 4 != m_dir1) begin
                    m_dir1 = d;
                    t1 = 1'b1;
                end
                d = decode(keyset_p2, c);
                if (d >= 0 && enable && d != m_dir2 && (d + 2) % 4 != m_dir2) begin
                    m_dir2 = d;
                    t2 = 1'b1;
                end
            end
        end else if (pfx.size() > 0) begin
            idle++;
            if (idle == T - 1) begin
                pfx.delete();
                idle = 0;
            end
        end
        return {2'(m_dir1), 2'(m_dir2), t1, t2};
    endfunction

    // One clock of stimulus; called at an active edge, returns at the next one.
    task automatic step(input logic v, input logic [7:0] c, input logic ld);
        exp_t e;
        #1;
        enable     = en_n;
        keyset_p1  = ks1_n;
        keyset_p2  = ks2_n;
        scan_valid = v;
        scan_code  = c;
        load       = ld;
        e.due = cyc + 1;
        e.ex  = model_step(v, c, ld);
        sbq.push_back(e);
        @(posedge clock);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        #1;
        scan_valid = 1'b0;
        load = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("rst_dir_p1", int'(dir_p1), 1);
        check("rst_dir_p2", int'(dir_p2), 3);
        check("rst_turns", int'({turn_p1, turn_p2}), 0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
    endtask

    // Scoreboard monitor: compares outputs against each due expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                n_chk++;
                if ({dir_p1, dir_p2, turn_p1, turn_p2} === e.ex) n_pass++;
                else $display("FAIL outs cyc=%0d: got d1=%0d d2=%0d t1=%0d t2=%0d expected d1=%0d d2=%0d t1=%0d t2=%0d",
                              cyc, dir_p1, dir_p2, turn_p1, turn_p2, e.ex[5:4], e.ex[3:2], e.ex[1], e.ex[0]);
            end
        end
    end

    initial begin
        int r, k, waited;
        logic [7:0] c;
        km[1][0] = 8'h1C; km[1][1] = 8'h23; km[1][2] = 8'h1D; km[1][3] = 8'h1B;
        km[2][0] = 8'h2B; km[2][1] = 8'h33; km[2][2] = 8'h2C; km[2][3] = 8'h34;
        km[3][0] = 8'h3B; km[3][1] = 8'h4B; km[3][2] = 8'h43; km[3][3] = 8'h42;
        km[4][0] = 8'h6B; km[4][1] = 8'h74; km[4][2] = 8'h75; km[4][3] = 8'h73;
        slot_dir[0] = 3; slot_dir[1] = 1; slot_dir[2] = 0; slot_dir[3] = 2;
        model_reset();

        @(posedge clock);
        en_n = 1'b1; ks1_n = 3'd1; ks2_n = 3'd4;
        do_reset();

        // basic make, reversal rejection, legal turn
        step(1'b1, 8'h1D, 1'b0);
        #2; check("p1_up_dir", int'(dir_p1), 0); check("p1_up_pulse", int'(turn_p1), 1);
        check("p2_hold", int'(dir_p2), 3);
        step(1'b1, 8'h1B, 1'b0);
        #2; check("p1_reverse_rej", int'(dir_p1), 0); check("p1_reverse_nopulse", int'(turn_p1), 0);
        step(1'b1, 8'h1C, 1'b0);
        #2; check("p1_left", int'(dir_p1), 3);

        // extended make, extended break
        step(1'b1, 8'hE0, 1'b0); step(1'b1, 8'h75, 1'b0);
        #2; check("p2_ext_up", int'(dir_p2), 0); check("p2_ext_pulse", int'(turn_p2), 1);
        step(1'b1, 8'hE0, 1'b0); step(1'b1, 8'hF0, 1'b0); step(1'b1, 8'h75, 1'b0);
        step(1'b1, 8'hF0, 1'b0); step(1'b1, 8'h23, 1'b0); step(1'b1, 8'h23, 1'b0);
        #2; check("p1_right_rej", int'(dir_p1), 3);

        // prefix timeout boundaries
        step(1'b1, 8'hE0, 1'b0); idle_n(T); step(1'b1, 8'hF0, 1'b0); step(1'b1, 8'h1D, 1'b0);
        #2; check("timeout_brk", int'(dir_p1), 3);
        step(1'b1, 8'hE0, 1'b0); idle_n(T - 2); step(1'b1, 8'hF0, 1'b0); step(1'b1, 8'h1D, 1'b0);
        #2; check("prefix_kept", int'(dir_p1), 3);
        step(1'b1, 8'h1D, 1'b0);
        #2; check("make_after", int'(dir_p1), 0);

        // shared keyset and load priority
        ks1_n = 3'd3; ks2_n = 3'd3;
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h43, 1'b0);
        #2; check("shared_both_up", int'({dir_p1, dir_p2, turn_p1, turn_p2}), 6'b00_00_11);
        step(1'b1, 8'h3B, 1'b1);
        #2; check("load_priority", int'({dir_p1, dir_p2, turn_p1, turn_p2}), 6'b01_11_00);

        // reset mid-sequence abandons the pending prefix
        ks1_n = 3'd1;
        step(1'b1, 8'hE0, 1'b0); step(1'b1, 8'hF0, 1'b0);
        do_reset();
        step(1'b1, 8'h1D, 1'b0);
        #2; check("after_reset_make", int'(dir_p1), 0);

        // randomized streams
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 19) == 0) ks1_n = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) ks2_n = 3'($urandom_range(0, 7));
            en_n = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 149) == 0) begin
                idle_n($urandom_range(T - 3, T + 2));
            end else if ($urandom_range(0, 9) < 3) begin
                step(1'b0, 8'($urandom), ($urandom_range(0, 39) == 0));
            end else begin
                r = $urandom_range(0, 9);
                if (r == 0)      c = 8'hE0;
                else if (r == 1) c = 8'hF0;
                else if (r < 8) begin
                    k = $urandom_range(1, 4);
                    c = km[k][$urandom_range(0, 3)];
                end else c = 8'($urandom);
                step(1'b1, c, ($urandom_range(0, 39) == 0));
            end
        end

        idle_n(3);
        waited = 0;
        while (sbq.size() > 0 && waited < 10) begin
            @(posedge clock);
            waited++;
        end
        #3;
        check("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ps2_direction_decoder.md
Name: ps2_direction_decoder

Overview:
- Converts the PS/2 keyboard byte stream into lightbike direction commands for two players.
- Sits between the PS/2 receiver and the game-state logic.
- Handles the make, break (F0) and extended (E0) prefixes and matches codes against each player's keyset.
- Keeps a registered heading per player, forbids 180° reversals, and pulses a strobe on each accepted turn.

Parameters:
- TIMEOUT_CYCLES, 50000, clock cycles allowed after a prefix byte before the prefix is discarded (1 ms at 50 MHz).
- CNT_W, 16, width of the prefix timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- scan_code  in  8  byte from PS/2 receiver
- scan_valid  in  1  one-cycle strobe; scan_code valid this cycle
- enable  in  1  game running; when low, headings are frozen but the prefix FSM keeps tracking
- load  in  1  synchronous round restart; headings return to their reset values
- keyset_p1  in  3  player 1 key set, 1..4
- keyset_p2  in  3  player 2 key set, 1..4
- dir_p1  out  2  player 1 heading: 0 up, 1 right, 2 down, 3 left
- dir_p2  out  2  player 2 heading, same encoding
- turn_p1  out  1  one-cycle pulse when dir_p1 changes due to a key
- turn_p2  out  1  one-cycle pulse when dir_p2 changes due to a key

Behaviour:
- Key map (left/right/up/down):
  - keyset 1: 1C/23/1D/1B
  - keyset 2: 2B/33/2C/34
  - keyset 3: 3B/4B/43/42
  - keyset 4: 6B/74/75/73
  - keyset 0, 5, 6, 7 decode as keyset 2.
- Keysets are used live (combinational compare); they are not latched.
- Prefix FSM, states IDLE, EXT, BRK, EXT_BRK. Every transition occurs only on a scan_valid cycle, except timeout.
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte is a make code -> evaluate; stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other byte -> make code (the E0 is ignored for matching) -> evaluate; go IDLE.
  - BRK and EXT_BRK: any byte is a release -> discarded; go IDLE. A byte of E0 or F0 here is also consumed as the released code.
- Timeout: the counter clears on every scan_valid. In any non-IDLE state it increments each cycle without scan_valid. On reaching TIMEOUT_CYCLES-1 the FSM returns to IDLE and the counter clears. In IDLE the counter holds 0.
- Evaluation, per player independently, in the cycle scan_valid is high:
  - If the code matches that player's keyset, call the result new.
  - The heading updates and the turn pulse fires only if all hold: enable=1, load=0, new != current, and new != current^2 (the reversal is rejected).
  - Otherwise the heading holds and no pulse fires.
- Register timing: dir_pX and turn_pX are registered and update on the edge that samples scan_valid. Latency is 1 cycle from scan_valid to the output.
- turn_pX is high for exactly 1 cycle per accepted turn and is never high without a dir change.
- Both players share one keyset: a single code may turn both players in the same cycle.
- load: dir_p1<=1, dir_p2<=3, turn_*<=0, FSM<=IDLE, counter<=0.
  - load has priority over a simultaneous scan_valid; that byte is dropped.
- Reset values: dir_p1=1 (right), dir_p2=3 (left), turn_p1=0, turn_p2=0, FSM=IDLE, counter=0.
- Reset mid-sequence, e.g. after E0 F0: any pending prefix is abandoned. The next byte is treated from IDLE.
- Unmatched make codes have no effect on headings. They still return EXT to IDLE.

Test Plan:
- Reset, keyset_p1=1, keyset_p2=4, enable=1; send 1D -> next cycle dir_p1=0, turn_p1=1 for 1 cycle; dir_p2 stays 3.
- With dir_p1=0, send 1B (down) -> rejected as a reversal: dir_p1 stays 0, no pulse. Then send 1C -> dir_p1=3 with a pulse.
- Send E0 75 -> dir_p2=0 with a pulse. Then send E0 F0 75 -> no change, no pulse, FSM back in IDLE.
- Send F0 23 -> no change (release of right). Then send 23 -> dir_p1 turns right only if not reversing from left; with dir_p1=3 it is rejected.
- Send E0, then idle TIMEOUT_CYCLES cycles, then F0 1D -> treated as a break from IDLE: no change. A repeat with only TIMEOUT_CYCLES-2 idle cycles -> the E0 F0 prefix still applies: no change; a following 1D make then turns if legal.
- keyset_p1=keyset_p2=3, headings 1 and 3; send 43 -> both go to 0 and both pulses fire in the same cycle. Assert load together with scan_valid 3B -> headings 1/3, no pulses.
